gf_inv_sbox_pipe: RTL and testbench
===================================

// Module: gf_inv_sbox_pipe
// PURPOSE
//  Pipelined AES inverse S-box (InvSubBytes) for the decryption datapath, LANES bytes/transfer.
//  Per byte: inverse affine -> change to normal basis [d^16,d] -> GF(2^8) inversion through
//  GF(2^4) subfield inverter ([alpha^8,alpha^2], [Omega^2,Omega]) -> change back to standard basis.
//  Sits between the round-key XOR and InvShiftRows/InvMixColumns; valid/ready on both sides.
// PARAMETERS
//  LANES      4   bytes processed in parallel per transfer (1..16)
//  TAG_W      4   width of opaque sideband tag carried alongside data (>=1)
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  in_valid   in   1          input transfer valid
//  in_ready   out  1          block can accept input this cycle
//  in_data    in   8*LANES    ciphertext-state bytes, lane i = in_data[8i+7:8i]
//  in_tag     in   TAG_W      sideband, returned unchanged with result
//  out_valid  out  1          result valid
//  out_ready  in   1          downstream accepts result
//  out_data   out  8*LANES    InvSbox per lane
//  out_tag    out  TAG_W      tag of the transfer in out_data
//  busy       out  1          any pipeline stage holds a valid transfer
// BEHAVIOUR
//  - Reset (async assert, sync deassert by system): all stage valids=0, out_valid=0,
//    out_data=0, out_tag=0, busy=0; in_ready=1 on the first cycle after reset release.
//  - 3 registered stages; latency exactly 3 cycles from accepted input to out_valid
//    when out_ready held 1. Throughput 1 transfer/cycle.
//    S1: inverse affine (x->A^-1(x^0x63)) + basis change to normal GF(2^8); register.
//    S2: form GF(2^4) value (hi^lo)^2*N + hi*lo, invert in GF(2^4); register inverse with hi,lo.
//    S3: two GF(2^4) mults (inv*lo, inv*hi) + basis change back; register to out_data.
//  - Transfer occurs on a port iff valid&&ready in the same cycle.
//  - Stall: stage k advances when stage k+1 empty or advancing; adv3 = ~out_valid | out_ready.
//    in_ready = ~v1 | adv1 (combinational from out_ready through chain; no bubble on full stall).
//  - Holding: while out_valid && !out_ready, out_data/out_tag stable; no transfer lost or duplicated.
//  - Full pipe (3 valid) with out_ready=0: in_ready=0. Simultaneous pop+push on full pipe: both occur.
//  - Tag and data stay aligned; ordering strictly FIFO.
//  - Reset mid-operation: in-flight transfers discarded, outputs return to reset values.
//  - Input 0x00 handled by GF inversion convention inv(0)=0 (no special-case mux).
//  - busy = v1|v2|v3.
// CONFIGURATION
//  SBOX_FWD_EN defined: extra port `fwd in 1`, sampled with in_data and pipelined with it;
//    fwd=1 selects forward S-box (basis change in at S1 without affine, affine+0x63 at S3);
//    fwd=0 inverse S-box. Latency/handshake identical; both paths share the GF inverter.
//  Not defined: no `fwd` port, inverse S-box only, affine logic for forward path absent.
// TESTING
//  1. LANES=4, in_data=0x0000_0063, out_ready=1 -> 3 cycles later out_data=0x5252_5200.
//  2. Exhaustive 0x00..0xFF on lane 0 back-to-back -> matches InvSbox table, e.g. 7C->01, ED->53, 16->FF.
//  3. Stream 6 transfers, out_ready=0 from cycle 2 for 5 cycles -> in_ready=0 after pipe fills,
//     all 6 outputs in order with correct tags, none dropped/duplicated.
//  4. Random valid/ready toggling 10k transfers -> scoreboard match, out_data stable during stall.
//  5. Assert rst_n=0 with 3 transfers in flight -> out_valid=0, busy=0 immediately; none emerge.
//  6. SBOX_FWD_EN: fwd=1 data 0x00 -> 0x63, 0x01 -> 0x7C; interleaved fwd=0 0x63 -> 0x00.

Source files
------------

// File: rtl/gf_inv_sbox_pipe.sv
// gf_inv_sbox_pipe: 3-stage AES S-box datapath (InvSubBytes by default), LANES bytes per
// transfer, valid/ready on both sides with a stall chain that leaves no bubble.
// The byte inverse is computed in a normal-basis tower GF(((2^2)^2)^2) built from
// [W^2,W], [Z^4,Z] and [Y^16,Y]; the basis-change matrices to and from the AES
// polynomial basis are derived at elaboration from the same tower arithmetic.
// Optional feature macro: SBOX_FWD_EN adds a `fwd` port that selects the forward S-box.
module gf_inv_sbox_pipe #(
   parameter int LANES = 4,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [8*LANES-1:0] in_data,
   input  logic [TAG_W-1:0]   in_tag,
`ifdef SBOX_FWD_EN
   input  logic               fwd,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8*LANES-1:0] out_data,
   output logic [TAG_W-1:0]   out_tag,
   output logic               busy
);

   // GF(2^4) = GF(2^2)[Z]/(Z^2+Z+N), N = W^2 in the [W^2,W] basis
   localparam logic [1:0] N4 = 2'b10;

   // GF(2^2) normal-basis multiply ([W^2,W], W^2+W+1=0)
   function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
      logic e;
      e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
      return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
   endfunction

   // squaring in a normal basis is a swap; in GF(2^2) it is also the inverse
   function automatic logic [1:0] gf4_sq(input logic [1:0] a);
      return {a[0], a[1]};
   endfunction

   function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
      logic [1:0] e;
      e = gf4_mul(gf4_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]), N4);
      return {gf4_mul(a[3:2], b[3:2]) ^ e, gf4_mul(a[1:0], b[1:0]) ^ e};
   endfunction

   // inverse via norm: theta = ((hi^lo)^2*N + hi*lo)^-1, result {theta*lo, theta*hi}; inv(0)=0
   function automatic logic [3:0] gf16_inv(input logic [3:0] a);
      logic [1:0] th;
      th = gf4_sq(gf4_mul(gf4_sq(a[3:2] ^ a[1:0]), N4) ^ gf4_mul(a[3:2], a[1:0]));
      return {gf4_mul(th, a[1:0]), gf4_mul(th, a[3:2])};
   endfunction

   // first nu for which Y^2+Y+nu has no root in GF(2^4), i.e. is irreducible
   function automatic logic [3:0] find_nu();
      logic [3:0] nu;
      logic       found;
      logic       irred;
      nu    = 4'h0;
      found = 1'b0;
      for (int c = 1; c < 16; c++) begin
         irred = 1'b1;
         for (int t = 0; t < 16; t++)
            if ((gf16_mul(4'(t), 4'(t)) ^ 4'(t)) == 4'(c)) irred = 1'b0;
         if (irred && !found) begin
            nu    = 4'(c);
            found = 1'b1;
         end
      end
      return nu;
   endfunction

   localparam logic [3:0] NU = find_nu();

   // AES polynomial-basis multiply, only used to derive the basis matrices
   function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   // a nonzero root r of r^2 + r = c in the AES field
   function automatic logic [7:0] find_root(input logic [7:0] c);
      logic [7:0] root;
      logic       found;
      root  = 8'h00;
      found = 1'b0;
      for (int i = 1; i < 256; i++)
         if (!found && ((gf256_mul(8'(i), 8'(i)) ^ 8'(i)) == c)) begin
            root  = 8'(i);
            found = 1'b1;
         end
      return root;
   endfunction

   function automatic logic [7:0] img4(input logic [1:0] b, input logic [7:0] w);
      return (b[1] ? gf256_mul(w, w) : 8'h00) ^ (b[0] ? w : 8'h00);
   endfunction

   function automatic logic [7:0] img16(input logic [3:0] a, input logic [7:0] w,
                                        input logic [7:0] z);
      logic [7:0] z2;
      z2 = gf256_mul(z, z);
      return gf256_mul(img4(a[3:2], w), gf256_mul(z2, z2)) ^ gf256_mul(img4(a[1:0], w), z);
   endfunction

   // columns k = AES-basis image of tower basis bit k
   function automatic logic [63:0] build_from(input logic [3:0] nu);
      logic [63:0] cols;
      logic [7:0]  w, z, y, y16, t;
      w   = find_root(8'h01);
      z   = find_root(img4(N4, w));
      y   = find_root(img16(nu, w, z));
      y16 = y;
      for (int s = 0; s < 4; s++) y16 = gf256_mul(y16, y16);
      cols = '0;
      for (int k = 0; k < 8; k++) begin
         t = 8'h01 << k;
         cols[8*k +: 8] = gf256_mul(img16(t[7:4], w, z), y16) ^ gf256_mul(img16(t[3:0], w, z), y);
      end
      return cols;
   endfunction

   // GF(2) matrix-vector product, matrix stored as 8 packed columns
   function automatic logic [7:0] mat_apply(input logic [63:0] cols, input logic [7:0] x);
      logic [7:0] r;
      r = 8'h00;
      for (int k = 0; k < 8; k++)
         if (x[k]) r = r ^ cols[8*k +: 8];
      return r;
   endfunction

   // inverse mapping found column by column: tower value whose image is AES bit j
   function automatic logic [63:0] build_to(input logic [63:0] from_cols);
      logic [63:0] cols;
      cols = '0;
      for (int j = 0; j < 8; j++)
         for (int t = 0; t < 256; t++)
            if (mat_apply(from_cols, 8'(t)) == (8'h01 << j)) cols[8*j +: 8] = 8'(t);
      return cols;
   endfunction

   localparam logic [63:0] FROM_T = build_from(NU);
   localparam logic [63:0] TO_T   = build_to(FROM_T);

   // x -> A^-1(x ^ 0x63), folded into rotations and the constant 0x05
   function automatic logic [7:0] inv_affine(input logic [7:0] x);
      return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
   endfunction

`ifdef SBOX_FWD_EN
   function automatic logic [7:0] fwd_affine(input logic [7:0] x);
      return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
   endfunction
`endif

   // S2 per lane: invert the GF(2^4) norm of the tower element
   function automatic logic [3:0] norm_inv(input logic [7:0] g);
      logic [3:0] s;
      s = g[7:4] ^ g[3:0];
      return gf16_inv(gf16_mul(gf16_mul(s, s), NU) ^ gf16_mul(g[7:4], g[3:0]));
   endfunction

   // S3 per lane: conjugate times theta, then back to the AES basis
   function automatic logic [7:0] finish_lane(input logic [3:0] th, input logic [7:0] g);
      return mat_apply(FROM_T, {gf16_mul(th, g[3:0]), gf16_mul(th, g[7:4])});
   endfunction

   logic                ld1, ld2, ld3;
   logic                v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic [8*LANES-1:0]  s1_data_q, s1_data_d;
   logic [TAG_W-1:0]    s1_tag_q, s1_tag_d;
   logic [4*LANES-1:0]  s2_theta_q, s2_theta_d;
   logic [8*LANES-1:0]  s2_g_q, s2_g_d;
   logic [TAG_W-1:0]    s2_tag_q, s2_tag_d;
   logic [8*LANES-1:0]  out_data_q, out_data_d;
   logic [TAG_W-1:0]    out_tag_q, out_tag_d;
`ifdef SBOX_FWD_EN
   logic                s1_fwd_q, s1_fwd_d, s2_fwd_q, s2_fwd_d;
`endif

   // stall chain and next-state for every stage
   always_comb begin
      // NOTE: every variable gets a default before any condition, so no latch is inferred
      ld3        = ~v3_q | out_ready;
      ld2        = ~v2_q | ld3;
      ld1        = ~v1_q | ld2;
      v1_d       = ld1 ? in_valid : v1_q;
      v2_d       = ld2 ? v1_q : v2_q;
      v3_d       = ld3 ? v2_q : v3_q;
      s1_data_d  = s1_data_q;
      s1_tag_d   = s1_tag_q;
      s2_theta_d = s2_theta_q;
      s2_g_d     = s2_g_q;
      s2_tag_d   = s2_tag_q;
      out_data_d = out_data_q;
      out_tag_d  = out_tag_q;
`ifdef SBOX_FWD_EN
      s1_fwd_d   = s1_fwd_q;
      s2_fwd_d   = s2_fwd_q;
`endif
      if (ld1 && in_valid) begin
         s1_tag_d = in_tag;
         for (int i = 0; i < LANES; i++) begin
`ifdef SBOX_FWD_EN
            s1_data_d[8*i +: 8] = mat_apply(TO_T, fwd ? in_data[8*i +: 8]
                                                       : inv_affine(in_data[8*i +: 8]));
`else
            s1_data_d[8*i +: 8] = mat_apply(TO_T, inv_affine(in_data[8*i +: 8]));
`endif
         end
`ifdef SBOX_FWD_EN
         s1_fwd_d = fwd;
`endif
      end
      if (ld2 && v1_q) begin
         s2_g_d   = s1_data_q;
         s2_tag_d = s1_tag_q;
         for (int i = 0; i < LANES; i++)
            s2_theta_d[4*i +: 4] = norm_inv(s1_data_q[8*i +: 8]);
`ifdef SBOX_FWD_EN
         s2_fwd_d = s1_fwd_q;
`endif
      end
      if (ld3 && v2_q) begin
         out_tag_d = s2_tag_q;
         for (int i = 0; i < LANES; i++) begin
`ifdef SBOX_FWD_EN
            out_data_d[8*i +: 8] = s2_fwd_q
                                 ? fwd_affine(finish_lane(s2_theta_q[4*i +: 4], s2_g_q[8*i +: 8]))
                                 : finish_lane(s2_theta_q[4*i +: 4], s2_g_q[8*i +: 8]);
`else
            out_data_d[8*i +: 8] = finish_lane(s2_theta_q[4*i +: 4], s2_g_q[8*i +: 8]);
`endif
         end
      end
   end

   // valid bits and visible outputs: cleared by reset
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together
      if (!rst_n) begin
         v1_q       <= 1'b0;
         v2_q       <= 1'b0;
         v3_q       <= 1'b0;
         out_data_q <= '0;
         out_tag_q  <= '0;
      end else begin
         v1_q       <= v1_d;
         v2_q       <= v2_d;
         v3_q       <= v3_d;
         out_data_q <= out_data_d;
         out_tag_q  <= out_tag_d;
      end
   end

   // interior datapath registers
   always_ff @(posedge clk) begin
      // NOTE: these are only ever read behind a valid bit, so they carry no reset
      s1_data_q  <= s1_data_d;
      s1_tag_q   <= s1_tag_d;
      s2_theta_q <= s2_theta_d;
      s2_g_q     <= s2_g_d;
      s2_tag_q   <= s2_tag_d;
`ifdef SBOX_FWD_EN
      s1_fwd_q   <= s1_fwd_d;
      s2_fwd_q   <= s2_fwd_d;
`endif
   end

   assign in_ready  = ld1;
   assign out_valid = v3_q;
   assign out_data  = out_data_q;
   assign out_tag   = out_tag_q;
   assign busy      = v1_q | v2_q | v3_q;

endmodule

// File: tb/tb_gf_inv_sbox_pipe.sv
// tb_gf_inv_sbox_pipe: scoreboard bench for gf_inv_sbox_pipe; reference tables are built
// from the AES field definition (brute-force inverse plus affine map).
module tb_gf_inv_sbox_pipe;

   localparam int LANES = 4;
   localparam int TAG_W = 4;

   typedef logic [TAG_W+8*LANES-1:0] sb_t;

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [8*LANES-1:0] in_data;
   logic [TAG_W-1:0]   in_tag;
   logic               fwd_s;
   logic               out_valid;
   logic               out_ready;
   logic [8*LANES-1:0] out_data;
   logic [TAG_W-1:0]   out_tag;
   logic               busy;

   int   checks;
   int   errors;
   int   out_count;
   sb_t  exp_q[$];
   sb_t  mon_exp;
   sb_t  prev_out;
   logic hold_prev;
   logic [7:0] sbox_tab[256];
   logic [7:0] inv_tab[256];

   gf_inv_sbox_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_tag    (in_tag),
`ifdef SBOX_FWD_EN
      .fwd       (fwd_s),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #(3_000_000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [7:0] bmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
      return p[7:0];
   endfunction

   task automatic build_tables();
      logic [7:0] inv, x, s, c;
      c = 8'h63;
      for (int v = 0; v < 256; v++) begin
         x   = 8'(v);
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (bmul(x, 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         sbox_tab[v] = s;
      end
      for (int v = 0; v < 256; v++) inv_tab[sbox_tab[v]] = 8'(v);
   endtask

   function automatic logic [31:0] model(input logic [31:0] d, input logic f);
      logic [31:0] r;
      for (int i = 0; i < LANES; i++)
         r[8*i +: 8] = f ? sbox_tab[d[8*i +: 8]] : inv_tab[d[8*i +: 8]];
      return r;
   endfunction

   // output monitor: scoreboard pop on every output transfer, plus hold-stability check
   always @(negedge clk) begin
      if (rst_n) begin
         if (hold_prev) begin
            checks++;
            if (out_valid !== 1'b1 || {out_tag, out_data} !== prev_out) begin
               errors++;
               $display("FAIL hold: valid=%b out=%h required valid=1 out=%h",
                        out_valid, {out_tag, out_data}, prev_out);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            out_count++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard: unexpected output %h, nothing outstanding",
                        {out_tag, out_data});
            end else begin
               mon_exp = exp_q.pop_front();
               if ({out_tag, out_data} !== mon_exp) begin
                  errors++;
                  $display("FAIL scoreboard: got %h required %h", {out_tag, out_data}, mon_exp);
               end
            end
         end
         hold_prev = out_valid && !out_ready;
         prev_out  = {out_tag, out_data};
      end else begin
         hold_prev = 1'b0;
      end
   end

   task automatic drive(input logic v, input logic [31:0] d, input logic [TAG_W-1:0] t,
                        input logic f, input logic r, output logic acc);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = d;
      in_tag    = t;
      fwd_s     = f;
      out_ready = r;
      @(negedge clk);
      acc = v && in_ready;
      if (acc) exp_q.push_back({t, model(d, f)});
   endtask

   task automatic drain();
      logic acc;
      for (int c = 0; c < 50 && exp_q.size() != 0; c++) drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d transfers outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0; fwd_s = 1'b0; out_ready = 1'b0;
      #3;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || out_tag !== '0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b busy=%b data=%h tag=%h required all 0",
                  out_valid, busy, out_data, out_tag);
      end
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b required 1", in_ready);
      end
   endtask

   // one transfer, then watch it emerge exactly 3 cycles later
   task automatic single_latency(input logic [31:0] d, input logic [31:0] req, input string nm);
      logic acc;
      drive(1'b1, d, 4'h5, 1'b0, 1'b1, acc);
      checks++;
      if (acc !== 1'b1) begin errors++; $display("FAIL %s_accept: got %b required 1", nm, acc); end
      for (int k = 1; k <= 3; k++) begin
         drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
         checks++;
         if (out_valid !== (k == 3)) begin
            errors++;
            $display("FAIL %s_latency: cycle %0d out_valid=%b required %b", nm, k, out_valid, k == 3);
         end
      end
      checks++;
      if (out_data !== req || out_tag !== 4'h5) begin
         errors++;
         $display("FAIL %s_data: got %h/%h required %h/5", nm, out_data, out_tag, req);
      end
      drain();
   endtask

   task automatic test_exhaustive();
      logic acc;
      logic [31:0] rnd;
      for (int i = 0; i < 256; i++) begin
         rnd = $urandom();
         drive(1'b1, {rnd[23:0], 8'(i)}, 4'(i), 1'b0, 1'b1, acc);
         checks++;
         if (acc !== 1'b1) begin
            errors++;
            $display("FAIL exhaustive_accept: byte %h got %b required 1", i, acc);
         end
      end
      drain();
   endtask

   task automatic test_stall();
      logic acc, r;
      logic [31:0] rnd;
      int idx, oc0;
      idx = 0;
      oc0 = out_count;
      for (int c = 0; c < 20; c++) begin
         r   = !(c >= 2 && c <= 6);
         rnd = $urandom();
         drive(idx < 6, rnd, 4'(idx), 1'b0, r, acc);
         if (c >= 3 && c <= 6) begin
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
               errors++;
               $display("FAIL stall_full: cycle %0d in_ready=%b busy=%b required 0/1",
                        c, in_ready, busy);
            end
         end
         if (c == 7) begin
            checks++;
            if (in_ready !== 1'b1) begin
               errors++;
               $display("FAIL stall_pop_push: in_ready=%b required 1", in_ready);
            end
         end
         if (acc) idx++;
      end
      drain();
      checks++;
      if (out_count - oc0 != 6) begin
         errors++;
         $display("FAIL stall_count: got %0d outputs required 6", out_count - oc0);
      end
   endtask

   task automatic test_random();
      logic acc, v, r, f;
      logic [31:0] rnd;
      int sent, oc0, cyc;
      sent = 0;
      cyc  = 0;
      oc0  = out_count;
      while (sent < 10000 && cyc < 60000) begin
         v   = $urandom_range(0, 3) != 0;
         r   = $urandom_range(0, 3) != 0;
         rnd = $urandom();
`ifdef SBOX_FWD_EN
         f   = 1'($urandom_range(0, 1));
`else
         f   = 1'b0;
`endif
         drive(v, rnd, 4'($urandom_range(0, 15)), f, r, acc);
         if (acc) sent++;
         cyc++;
      end
      checks++;
      if (sent != 10000) begin
         errors++;
         $display("FAIL random_budget: sent %0d required 10000", sent);
      end
      drain();
      checks++;
      if (out_count - oc0 != sent) begin
         errors++;
         $display("FAIL random_count: got %0d outputs required %0d", out_count - oc0, sent);
      end
   endtask

   task automatic test_reset_midflight();
      logic acc, seen;
      for (int i = 0; i < 3; i++) drive(1'b1, $urandom(), 4'(i), 1'b0, 1'b0, acc);
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || out_tag !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: valid=%b busy=%b data=%h tag=%h required all 0",
                  out_valid, busy, out_data, out_tag);
      end
      exp_q.delete();
      @(posedge clk); #1; rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
         if (out_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL midreset_discard: out_valid seen=%b required 0", seen);
      end
   endtask

`ifdef SBOX_FWD_EN
   task automatic test_fwd();
      logic acc;
      logic [31:0] req[3];
      req[0] = 32'h63637C63;
      req[1] = 32'h52525200;
      req[2] = 32'h6363637C;
      drive(1'b1, 32'h00000100, 4'h1, 1'b1, 1'b1, acc);
      drive(1'b1, 32'h00000063, 4'h2, 1'b0, 1'b1, acc);
      drive(1'b1, 32'h00000001, 4'h3, 1'b1, 1'b1, acc);
      for (int k = 1; k <= 3; k++) begin
         drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
         checks++;
         if (out_valid !== 1'b1 || out_data !== req[k-1]) begin
            errors++;
            $display("FAIL fwd_mix: slot %0d valid=%b data=%h required 1/%h",
                     k, out_valid, out_data, req[k-1]);
         end
      end
      drain();
   endtask
`endif

   initial begin
      checks    = 0;
      errors    = 0;
      out_count = 0;
      hold_prev = 1'b0;
      build_tables();
      test_reset();
      single_latency(32'h00000063, 32'h52525200, "single");
      single_latency(32'h16ED7C63, 32'hFF530100, "known");
      test_exhaustive();
      test_stall();
      test_random();
      test_reset_midflight();
`ifdef SBOX_FWD_EN
      test_fwd();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
